hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
- Backward-flowing control for the 5-stage pipeline. The F/D, D/X, X/M and M/W latches carry instructions and operands forward; this block sends stall and flush commands back to PC, F/D and D/X.
- Detects load-use hazards and taken-branch flushes.
- Holds the pipeline through multi-cycle mult/div using a BUSY state machine with a cycle counter and timeout.
- Sits beside decode; consumes the instruction words held in the F/D and D/X latches.

Parameters:
- MD_MAX_CYCLES, 32, cycles allowed in MD_BUSY before a timeout is flagged.
- CW, $clog2(MD_MAX_CYCLES+1), width of the mult/div cycle counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- fd_insn  in  32  instruction in the F/D latch (decode stage)
- dx_insn  in  32  instruction in the D/X latch (execute stage)
- branch_taken  in  1  taken branch/jump resolved in X this cycle
- md_start  in  1  1-cycle pulse: X issues mult/div operands
- md_rdy  in  1  mult/div result valid this cycle
- stall_pc  out  1  hold PC
- stall_fd  out  1  hold F/D latch
- stall_dx  out  1  hold D/X latch and X stage
- flush_fd  out  1  load nop into F/D
- flush_dx  out  1  load nop into D/X (bubble)
- md_busy  out  1  FSM in MD_BUSY
- md_err  out  1  sticky timeout flag
- md_cycles  out  CW  cycles spent in current/last mult/div
- perf_stalls  out  32  stall-cycle count (optional feature)
- perf_flushes  out  32  flush-event count (optional feature)

Behaviour:
- Instruction fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12]. Register 0 never causes a hazard.
- Read set of fd_insn:
  - R-type (00000): rs, rt
  - addi 00101, lw 01000: rs
  - sw 00111, bne 00010, blt 00110: rd, rs
  - all others: none
- Load-use: dx_insn opcode 01000, its rd != 0, and rd is in the read set of fd_insn → stall_pc=stall_fd=1 and flush_dx=1 for exactly that cycle. The stall clears automatically when the bubble advances.
- Branch: branch_taken=1 → flush_fd=flush_dx=1 and all stalls=0, same cycle. Branch has priority over load-use.
- State IDLE:
  - md_start=1 and md_rdy=0 → stall_pc, stall_fd, stall_dx=1 combinationally. Next state MD_BUSY, md_cycles←1.
  - md_start=1 and md_rdy=1 → no stall, stay IDLE, md_cycles←0.
- State MD_BUSY:
  - md_busy=1.
  - All three stalls=1 while md_rdy=0; md_cycles increments each cycle.
  - md_rdy=1 → stalls=0 that cycle so X/M captures the result; next state IDLE; md_cycles holds its final value.
  - md_cycles==MD_MAX_CYCLES with md_rdy=0 → md_err←1 (sticky), next state IDLE, stalls drop the following cycle.
  - md_start, branch_taken and load-use checks are ignored in MD_BUSY.
- Outputs: combinational from state and inputs. State, md_cycles, md_err and perf counters are registered.
- Reset (asynchronous, any time, including mid-MD_BUSY):
  - state→IDLE; md_cycles, md_err, perf counters→0.
  - All stall/flush outputs read 0 while reset_n=0, regardless of inputs.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_stalls increments every cycle stall_pc=1.
  - perf_flushes increments every cycle flush_fd|flush_dx=1.
  - Both 32-bit and saturating at all ones.
- Undefined: both ports driven constant 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT)
  - field index constants
  - 2-state FSM enum md_state_t
  - function reads_reg(insn, r) returning whether insn reads register r
- One natural sub-module, md_busy_fsm: state, md_cycles, md_err. The top-level block holds the combinational hazard/priority logic and the perf counters.

Test Plan:
- Load-use: dx_insn = lw r5, fd_insn = add r1,r5,r2 → stall_pc=stall_fd=flush_dx=1 for 1 cycle. Same case with rd=r0 → no stall.
- Branch priority: branch_taken=1 while load-use condition holds → flush_fd=flush_dx=1, stall_pc=0.
- Mult/div: md_start at cycle 0, md_rdy at cycle 17 → stalls=1 on cycles 0–16, 0 on cycle 17; md_cycles=17; md_busy falls at cycle 18.
- Zero-latency: md_start=md_rdy=1 same cycle → no stall, state stays IDLE.
- Timeout: md_start, md_rdy never asserted → md_err=1 after 32 busy cycles, stalls drop next cycle, md_err persists through later md_start until reset_n=0.
- Reset mid-busy: reset_n low at busy cycle 5 → all outputs 0 immediately. After release, fd/dx idle → stalls=0. With HAZARD_PERF_EN: perf_stalls=0 after reset, then counts 1 per stall cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcodes, field positions, mult/div FSM states and the register-read decoder
// for the pipeline hazard control block.
package hazard_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RD_HI = 26;
  localparam int RD_LO = 22;
  localparam int RS_HI = 21;
  localparam int RS_LO = 17;
  localparam int RT_HI = 16;
  localparam int RT_LO = 12;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Register 0 is hardwired, so it never appears in a read set.
  function automatic logic reads_reg(input logic [31:0] insn, input logic [4:0] r);
    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       hit;
    op  = insn[OP_HI:OP_LO];
    rd  = insn[RD_HI:RD_LO];
    rs  = insn[RS_HI:RS_LO];
    rt  = insn[RT_HI:RT_LO];
    hit = 1'b0;
    case (op)
      OP_RTYPE:                hit = (rs == r) || (rt == r);
      OP_ADDI, OP_LW:          hit = (rs == r);
      OP_SW, OP_BNE, OP_BLT:   hit = (rd == r) || (rs == r);
      default:                 hit = 1'b0;
    endcase
    return hit && (r != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Bundle of pipeline-facing signals for hazard_control: instruction words and
// mult/div handshake in, stall/flush commands and status out.
interface hazard_control_if #(
  parameter int CW = 6
);

  logic [31:0]   fd_insn;
  logic [31:0]   dx_insn;
  logic          branch_taken;
  logic          md_start;
  logic          md_rdy;
  logic          stall_pc;
  logic          stall_fd;
  logic          stall_dx;
  logic          flush_fd;
  logic          flush_dx;
  logic          md_busy;
  logic          md_err;
  logic [CW-1:0] md_cycles;
  logic [31:0]   perf_stalls;
  logic [31:0]   perf_flushes;

  modport master (
    output fd_insn, dx_insn, branch_taken, md_start, md_rdy,
    input  stall_pc, stall_fd, stall_dx, flush_fd, flush_dx,
    input  md_busy, md_err, md_cycles, perf_stalls, perf_flushes
  );

  modport slave (
    input  fd_insn, dx_insn, branch_taken, md_start, md_rdy,
    output stall_pc, stall_fd, stall_dx, flush_fd, flush_dx,
    output md_busy, md_err, md_cycles, perf_stalls, perf_flushes
  );

endinterface

// File: rtl/md_busy_fsm.sv
// Mult/div busy tracker: holds the pipeline while a multi-cycle op runs, counts its
// cycles and raises a sticky error if the unit never answers.
module md_busy_fsm
  import hazard_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 32,
  parameter int CW            = $clog2(MD_MAX_CYCLES + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          md_start,
  input  logic          md_rdy,
  output logic          md_busy,
  output logic          md_stall,
  output logic          md_err,
  output logic [CW-1:0] md_cycles
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MD_MAX_CYCLES);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          err_q, err_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= MD_IDLE;
      cycles_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
    end
  end

  // On timeout the stall is still held this cycle; it drops once back in IDLE.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    err_d    = err_q;
    md_stall = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          if (md_rdy) begin
            cycles_d = '0;
          end else begin
            md_stall = 1'b1;
            state_d  = MD_BUSY;
            cycles_d = CW'(1);
          end
        end
      end
      MD_BUSY: begin
        if (md_rdy) begin
          state_d = MD_IDLE;
        end else begin
          md_stall = 1'b1;
          if (cycles_q == MAX_CNT) begin
            err_d   = 1'b1;
            state_d = MD_IDLE;
          end else begin
            cycles_d = cycles_q + CW'(1);
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_busy   = (state_q == MD_BUSY);
  assign md_err    = err_q;
  assign md_cycles = cycles_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and mult/div holds.
// Define HAZARD_PERF_EN to build saturating stall/flush performance counters.
module hazard_control
  import hazard_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 32,
  parameter int CW            = $clog2(MD_MAX_CYCLES + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  hazard_control_if.slave bus
);

  logic          mdBusy;
  logic          mdStall;
  logic          mdErr;
  logic [CW-1:0] mdCycles;
  logic [4:0]    dxRd;
  logic          dxIsLoad;
  logic          loadUse;
  logic          stallPc;
  logic          stallFd;
  logic          stallDx;
  logic          flushFd;
  logic          flushDx;

  md_busy_fsm #(
    .MD_MAX_CYCLES(MD_MAX_CYCLES),
    .CW           (CW)
  ) u_md_busy_fsm (
    .clock    (clock),
    .reset_n  (reset_n),
    .md_start (bus.md_start),
    .md_rdy   (bus.md_rdy),
    .md_busy  (mdBusy),
    .md_stall (mdStall),
    .md_err   (mdErr),
    .md_cycles(mdCycles)
  );

  assign dxRd     = bus.dx_insn[RD_HI:RD_LO];
  assign dxIsLoad = (bus.dx_insn[OP_HI:OP_LO] == OP_LW);
  assign loadUse  = dxIsLoad && (dxRd != 5'd0) && reads_reg(bus.fd_insn, dxRd);

  // While busy the mult/div hold owns the pipeline; hazards and branches wait.
  // Otherwise a taken branch overrides any stall so the wrong path is discarded.
  always_comb begin
    stallPc = 1'b0;
    stallFd = 1'b0;
    stallDx = 1'b0;
    flushFd = 1'b0;
    flushDx = 1'b0;
    if (!reset_n) begin
      stallPc = 1'b0;
    end else if (mdBusy) begin
      stallPc = mdStall;
      stallFd = mdStall;
      stallDx = mdStall;
    end else if (bus.branch_taken) begin
      flushFd = 1'b1;
      flushDx = 1'b1;
    end else begin
      stallPc = mdStall || loadUse;
      stallFd = mdStall || loadUse;
      stallDx = mdStall;
      flushDx = loadUse;
    end
  end

  assign bus.stall_pc  = stallPc;
  assign bus.stall_fd  = stallFd;
  assign bus.stall_dx  = stallDx;
  assign bus.flush_fd  = flushFd;
  assign bus.flush_dx  = flushDx;
  assign bus.md_busy   = mdBusy;
  assign bus.md_err    = mdErr;
  assign bus.md_cycles = mdCycles;

`ifdef HAZARD_PERF_EN
  logic [31:0] perfStalls_q, perfStalls_d;
  logic [31:0] perfFlushes_q, perfFlushes_d;

  // Both counters stick at all ones instead of wrapping.
  always_comb begin
    perfStalls_d  = perfStalls_q;
    perfFlushes_d = perfFlushes_q;
    if (stallPc && (perfStalls_q != 32'hFFFF_FFFF)) begin
      perfStalls_d = perfStalls_q + 32'd1;
    end
    if ((flushFd || flushDx) && (perfFlushes_q != 32'hFFFF_FFFF)) begin
      perfFlushes_d = perfFlushes_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perfStalls_q  <= '0;
      perfFlushes_q <= '0;
    end else begin
      perfStalls_q  <= perfStalls_d;
      perfFlushes_q <= perfFlushes_d;
    end
  end

  assign bus.perf_stalls  = perfStalls_q;
  assign bus.perf_flushes = perfFlushes_q;
`else
  assign bus.perf_stalls  = '0;
  assign bus.perf_flushes = '0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Directed testbench for hazard_control with hand-computed expectations.
module tb_hazard_control;

  localparam int MAXC = 32;
  localparam int CW   = $clog2(MAXC + 1);

  logic clock;
  logic reset_n;
  int   testCount;
  int   failCount;

  hazard_control_if #(.CW(CW)) bus ();

  hazard_control #(.MD_MAX_CYCLES(MAXC), .CW(CW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mkInsn(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx,
                               input logic br, input logic start, input logic rdy);
    bus.fd_insn      = fd;
    bus.dx_insn      = dx;
    bus.branch_taken = br;
    bus.md_start     = start;
    bus.md_rdy       = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkStalls(input string tag, input logic pc, input logic fd,
                             input logic dx, input logic ffd, input logic fdx);
    checkOutput({tag, "_stall"}, {29'd0, bus.stall_pc, bus.stall_fd, bus.stall_dx},
                {29'd0, pc, fd, dx});
    checkOutput({tag, "_flush"}, {30'd0, bus.flush_fd, bus.flush_dx}, {30'd0, ffd, fdx});
  endtask

  logic [31:0] lwR5, addUsesR5, lwR0, addUsesR0, lwR7, swR7, addiR7;

  initial begin
    testCount = 0;
    failCount = 0;
    lwR5      = mkInsn(5'b01000, 5'd5, 5'd3, 5'd0);
    addUsesR5 = mkInsn(5'b00000, 5'd1, 5'd5, 5'd2);
    lwR0      = mkInsn(5'b01000, 5'd0, 5'd3, 5'd0);
    addUsesR0 = mkInsn(5'b00000, 5'd1, 5'd0, 5'd2);
    lwR7      = mkInsn(5'b01000, 5'd7, 5'd3, 5'd0);
    swR7      = mkInsn(5'b00111, 5'd7, 5'd4, 5'd0);
    addiR7    = mkInsn(5'b00101, 5'd7, 5'd3, 5'd0);

    // Reset asserted with hazards present: every command must stay low.
    reset_n = 1'b0;
    applyStimulus(addUsesR5, lwR5, 1'b1, 1'b1, 1'b0);
    checkStalls("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_busy", {31'd0, bus.md_busy}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.md_err}, 32'd0);
    checkOutput("reset_cycles", 32'(bus.md_cycles), 32'd0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    checkStalls("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use on r5 then bubble advances.
    applyStimulus(addUsesR5, lwR5, 1'b0, 1'b0, 1'b0);
    checkStalls("loaduse", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(addUsesR5, 32'd0, 1'b0, 1'b0, 1'b0);
    checkStalls("loaduse_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(addUsesR0, lwR0, 1'b0, 1'b0, 1'b0);
    checkStalls("loaduse_r0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(swR7, lwR7, 1'b0, 1'b0, 1'b0);
    checkStalls("loaduse_sw_rd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(addiR7, lwR7, 1'b0, 1'b0, 1'b0);
    checkStalls("addi_rd_only", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(addUsesR5, lwR5, 1'b1, 1'b0, 1'b0);
    checkStalls("branch_prio", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();

    // Zero-latency mult/div.
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    checkStalls("md_zero", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("md_zero_busy", {31'd0, bus.md_busy}, 32'd0);
    checkOutput("md_zero_cycles", 32'(bus.md_cycles), 32'd0);

    // 17-cycle mult/div; a branch during busy is ignored.
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkStalls("md_c0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(addUsesR5, lwR5, (c == 5), 1'b0, 1'b0);
      checkStalls($sformatf("md_c%0d", c), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("md_busy_c%0d", c), {31'd0, bus.md_busy}, 32'd1);
      tick();
    end
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkStalls("md_c17", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("md_busy_c17", {31'd0, bus.md_busy}, 32'd1);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("md_busy_c18", {31'd0, bus.md_busy}, 32'd0);
    checkOutput("md_cycles_17", 32'(bus.md_cycles), 32'd17);
    checkOutput("md_err_ok", {31'd0, bus.md_err}, 32'd0);

    // Timeout after 32 busy cycles.
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int c = 1; c <= MAXC; c++) begin
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("to_stall_c%0d", c), {31'd0, bus.stall_pc}, 32'd1);
      checkOutput($sformatf("to_err_c%0d", c), {31'd0, bus.md_err}, 32'd0);
      tick();
    end
    checkOutput("to_err", {31'd0, bus.md_err}, 32'd1);
    checkOutput("to_busy", {31'd0, bus.md_busy}, 32'd0);
    checkOutput("to_cycles", 32'(bus.md_cycles), 32'd32);
    checkStalls("to_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("to_err_sticky", {31'd0, bus.md_err}, 32'd1);
    checkOutput("to_next_cycles", 32'(bus.md_cycles), 32'd1);

    // Reset in the middle of a busy period.
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c < 5; c++) tick();
    checkOutput("mid_busy_cycles", 32'(bus.md_cycles), 32'd5);
    reset_n = 1'b0;
    #1;
    checkStalls("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_reset_busy", {31'd0, bus.md_busy}, 32'd0);
    checkOutput("mid_reset_err", {31'd0, bus.md_err}, 32'd0);
    checkOutput("mid_reset_cycles", 32'(bus.md_cycles), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkStalls("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("perf_stalls_rst", bus.perf_stalls, 32'd0);
    checkOutput("perf_flushes_rst", bus.perf_flushes, 32'd0);

    applyStimulus(addUsesR5, lwR5, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
    checkOutput("perf_stalls_1", bus.perf_stalls, 32'd1);
    checkOutput("perf_flushes_1", bus.perf_flushes, 32'd1);
`else
    checkOutput("perf_stalls_off", bus.perf_stalls, 32'd0);
    checkOutput("perf_flushes_off", bus.perf_flushes, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
